// File: rtl/imem_loader.sv
// Instruction-memory loader: synchronises the pad beat bus into clk_int and
// assembles MSB-first address/data beats into single-cycle imem writes.
//
// state | meaning
// IDLE  | waiting for load_en
// ADDR  | collecting address beats
// DATA  | collecting data beats
// WRITE | imem_write pulse cycle
module imem_loader #(
   parameter int D_WIDTH     = 8,
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 40,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_int,
   input  logic                  reset,
   input  logic                  load_en,
   input  logic                  auto_inc,
   input  logic                  pad_strobe,
   input  logic [D_WIDTH-1:0]    pad_data,
   output logic [ADDR_WIDTH-1:0] imem_write_adr,
   output logic [DATA_WIDTH-1:0] imem_in,
   output logic                  imem_write,
   output logic                  busy,
   output logic                  frame_err,
   output logic [ADDR_WIDTH:0]   write_count
);

   localparam int A_BEATS   = (ADDR_WIDTH + D_WIDTH - 1) / D_WIDTH;
   localparam int D_BEATS   = (DATA_WIDTH + D_WIDTH - 1) / D_WIDTH;
   localparam int MAX_BEATS = (A_BEATS > D_BEATS) ? A_BEATS : D_BEATS;
   localparam int CNT_W     = $clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A_BEATS - 1);
   localparam logic [CNT_W-1:0] D_LAST = CNT_W'(D_BEATS - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, WRITE} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [ADDR_WIDTH-1:0]   addr_shreg;
   logic [ADDR_WIDTH-1:0]   adr_reg;
   logic [DATA_WIDTH-1:0]   data_shreg;

   logic [SYNC_STAGES-1:0]  load_sync;
   logic [SYNC_STAGES-1:0]  inc_sync;
   logic [SYNC_STAGES-1:0]  strobe_sync;
   logic [D_WIDTH-1:0]      data_sync [SYNC_STAGES];
   logic                    strobe_prev;
   logic                    load_prev;

   logic                    load_s;
   logic                    inc_s;
   logic                    load_rise;
   logic                    beat;
   logic [D_WIDTH-1:0]      beat_data;
   logic [ADDR_WIDTH-1:0]   addr_next;
   logic [DATA_WIDTH-1:0]   data_next;

   assign load_s    = load_sync[SYNC_STAGES-1];
   assign inc_s     = inc_sync[SYNC_STAGES-1];
   assign load_rise = load_s & ~load_prev;
   assign beat      = strobe_sync[SYNC_STAGES-1] & ~strobe_prev;
   assign beat_data = data_sync[SYNC_STAGES-1];

   // Concatenation equals (shreg << D_WIDTH) | data; the cast drops excess MSBs.
   assign addr_next = ADDR_WIDTH'({addr_shreg, beat_data});
   assign data_next = DATA_WIDTH'({data_shreg, beat_data});

   assign busy = ((state == ADDR) || (state == DATA)) && (cnt != '0);

   always_ff @(posedge clk_int) begin
      if (reset) begin
         load_sync   <= '0;
         inc_sync    <= '0;
         strobe_sync <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
         strobe_prev <= 1'b0;
         load_prev   <= 1'b0;
      end else begin
         load_sync   <= {load_sync[SYNC_STAGES-2:0], load_en};
         inc_sync    <= {inc_sync[SYNC_STAGES-2:0], auto_inc};
         strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], pad_strobe};
         data_sync[0] <= pad_data;
         for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
         strobe_prev <= strobe_sync[SYNC_STAGES-1];
         load_prev   <= load_s;
      end
   end

   always_ff @(posedge clk_int) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         addr_shreg     <= '0;
         adr_reg        <= '0;
         data_shreg     <= '0;
         imem_write_adr <= '0;
         imem_in        <= '0;
         imem_write     <= 1'b0;
         frame_err      <= 1'b0;
         write_count    <= '0;
      end else begin
         imem_write <= 1'b0;
         if (load_rise) frame_err <= 1'b0;
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (load_s) state <= ADDR;
            end
            ADDR: begin
               if (!load_s) begin
                  state <= IDLE;
                  cnt   <= '0;
                  if (busy) frame_err <= 1'b1;
               end else if (beat) begin
                  addr_shreg <= addr_next;
                  if (cnt == A_LAST) begin
                     adr_reg <= addr_next;
                     cnt     <= '0;
                     state   <= DATA;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (!load_s) begin
                  state <= IDLE;
                  cnt   <= '0;
                  if (busy) frame_err <= 1'b1;
               end else if (beat) begin
                  data_shreg <= data_next;
                  if (cnt == D_LAST) begin
                     // Outputs change only here so they hold stable between writes.
                     imem_in        <= data_next;
                     imem_write_adr <= adr_reg;
                     imem_write     <= 1'b1;
                     cnt            <= '0;
                     state          <= WRITE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            WRITE: begin
               if (~&write_count) write_count <= write_count + 1'b1;
               if (!load_s) begin
                  state <= IDLE;
               end else if (inc_s) begin
                  adr_reg <= adr_reg + 1'b1;
                  state   <= DATA;
               end else begin
                  state <= ADDR;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: default build plus a narrow-parameter build.
module tb_imem_loader;

   logic       clk_int = 1'b0;
   logic       reset = 1'b1;
   logic       load_en = 1'b0;
   logic       p_load_en = 1'b0;
   logic       auto_inc = 1'b0;
   logic       pad_strobe = 1'b0;
   logic [7:0] pad_data = 8'h00;

   logic [9:0]  imem_write_adr;
   logic [39:0] imem_in;
   logic        imem_write, busy, frame_err;
   logic [10:0] write_count;

   logic [5:0]  p_adr;
   logic [9:0]  p_in;
   logic        p_write, p_busy, p_err;
   logic [6:0]  p_count;

   int n_tests = 0;
   int n_fail  = 0;
   int wr_n    = 0;
   int p_wr_n  = 0;
   logic [9:0]  wr_adr [$];
   logic [39:0] wr_dat [$];

   imem_loader dut (
      .clk_int(clk_int), .reset(reset), .load_en(load_en), .auto_inc(auto_inc),
      .pad_strobe(pad_strobe), .pad_data(pad_data),
      .imem_write_adr(imem_write_adr), .imem_in(imem_in), .imem_write(imem_write),
      .busy(busy), .frame_err(frame_err), .write_count(write_count)
   );

   imem_loader #(.D_WIDTH(4), .ADDR_WIDTH(6), .DATA_WIDTH(10), .SYNC_STAGES(3)) dut_p (
      .clk_int(clk_int), .reset(reset), .load_en(p_load_en), .auto_inc(auto_inc),
      .pad_strobe(pad_strobe), .pad_data(pad_data[3:0]),
      .imem_write_adr(p_adr), .imem_in(p_in), .imem_write(p_write),
      .busy(p_busy), .frame_err(p_err), .write_count(p_count)
   );

   always #5 clk_int = ~clk_int;

   always @(negedge clk_int) begin
      if (imem_write) begin
         wr_n++;
         wr_adr.push_back(imem_write_adr);
         wr_dat.push_back(imem_in);
      end
      if (p_write) p_wr_n++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [7:0] d);
      pad_data = d;
      @(posedge clk_int); #1;
      pad_strobe = 1'b1;
      repeat (5) @(posedge clk_int);
      #1;
      pad_strobe = 1'b0;
      repeat (5) @(posedge clk_int);
      #1;
   endtask

   // Final data beat with the write pulse checked edge by edge after first sample.
   task automatic timed_beat(input logic [7:0] d, input int stages, input bit is_p);
      pad_data = d;
      @(posedge clk_int); #1;
      pad_strobe = 1'b1;
      for (int i = 0; i <= stages + 1; i++) begin
         @(posedge clk_int); #1;
         chk($sformatf("latency_edge%0d", i), is_p ? p_write : imem_write, (i == stages));
      end
      pad_strobe = 1'b0;
      repeat (5) @(posedge clk_int);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_adr"}, imem_write_adr, 0);
      chk({tag, "_in"}, imem_in, 0);
      chk({tag, "_write"}, imem_write, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, frame_err, 0);
      chk({tag, "_count"}, write_count, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk_int);
      #1;
      chk_zero("reset");
      reset = 1'b0;

      // Full frame, defaults
      load_en = 1'b1;
      repeat (5) @(posedge clk_int);
      #1;
      beat(8'h01); beat(8'h23);
      beat(8'hAA); beat(8'hBB); beat(8'hCC); beat(8'hDD);
      chk("busy_mid_frame", busy, 1);
      timed_beat(8'hEE, 2, 1'b0);
      chk("f1_writes", wr_n, 1);
      chk("f1_adr", imem_write_adr, 10'h123);
      chk("f1_in", imem_in, 40'hAABBCCDDEE);
      chk("f1_count", write_count, 1);
      chk("f1_busy", busy, 0);

      // Auto-increment with wrap
      auto_inc = 1'b1;
      beat(8'h03); beat(8'hFE);
      beat(8'h10); beat(8'h20); beat(8'h30); beat(8'h40); beat(8'h50);
      beat(8'h61); beat(8'h62); beat(8'h63); beat(8'h64); beat(8'h65);
      auto_inc = 1'b0;
      beat(8'h71); beat(8'h72); beat(8'h73); beat(8'h74); beat(8'h75);
      chk("ai_writes", wr_n, 4);
      chk("ai_adr0", wr_adr[1], 10'h3FE);
      chk("ai_dat0", wr_dat[1], 40'h1020304050);
      chk("ai_adr1", wr_adr[2], 10'h3FF);
      chk("ai_dat1", wr_dat[2], 40'h6162636465);
      chk("ai_adr2", wr_adr[3], 10'h000);
      chk("ai_dat2", wr_dat[3], 40'h7172737475);
      chk("ai_count", write_count, 4);

      // Address truncation
      beat(8'hFF); beat(8'hFF);
      beat(8'h12); beat(8'h34); beat(8'h56); beat(8'h78); beat(8'h9A);
      chk("tr_writes", wr_n, 5);
      chk("tr_adr", imem_write_adr, 10'h3FF);
      chk("tr_in", imem_in, 40'h123456789A);

      // Abort mid-frame
      beat(8'h01); beat(8'h02); beat(8'h03);
      chk("ab_busy_before", busy, 1);
      load_en = 1'b0;
      repeat (6) @(posedge clk_int);
      #1;
      chk("ab_err", frame_err, 1);
      chk("ab_busy", busy, 0);
      chk("ab_writes", wr_n, 5);
      chk("ab_count", write_count, 5);
      chk("ab_adr_hold", imem_write_adr, 10'h3FF);
      load_en = 1'b1;
      repeat (6) @(posedge clk_int);
      #1;
      chk("ab_err_clear", frame_err, 0);
      beat(8'h00); beat(8'h42);
      beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44); beat(8'h55);
      chk("ab2_writes", wr_n, 6);
      chk("ab2_adr", imem_write_adr, 10'h042);
      chk("ab2_in", imem_in, 40'h1122334455);
      chk("ab2_count", write_count, 6);

      // Reset mid-frame
      beat(8'h01); beat(8'h02); beat(8'h03); beat(8'h04);
      reset = 1'b1;
      repeat (2) @(posedge clk_int);
      #1;
      chk_zero("rst_mid");
      reset = 1'b0;
      repeat (6) @(posedge clk_int);
      #1;
      chk("rst_no_err", frame_err, 0);
      beat(8'h01); beat(8'h55);
      beat(8'hDE); beat(8'hAD); beat(8'hBE); beat(8'hEF); beat(8'h01);
      chk("rst2_writes", wr_n, 7);
      chk("rst2_adr", imem_write_adr, 10'h155);
      chk("rst2_in", imem_in, 40'hDEADBEEF01);
      chk("rst2_count", write_count, 1);

      // Narrow parameter build: 2 address + 3 data beats, 3-stage sync
      load_en = 1'b0;
      p_load_en = 1'b1;
      repeat (6) @(posedge clk_int);
      #1;
      chk("dflt_idle_err", frame_err, 0);
      beat(8'h0A); beat(8'h05);
      beat(8'h0F); beat(8'h0C);
      chk("p_busy_mid", p_busy, 1);
      timed_beat(8'h07, 3, 1'b1);
      chk("p_writes", p_wr_n, 1);
      chk("p_adr", p_adr, 6'h25);
      chk("p_in", p_in, 10'h3C7);
      chk("p_count", p_count, 1);
      chk("p_busy", p_busy, 0);
      chk("p_err", p_err, 0);
      chk("dflt_ignored", wr_n, 7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
